// File: rtl/synth_voice_allocator_if.sv
// Event and voice-output bundle between the event source, the allocator
// and the synthesizer core.
//
// Handshake: an event transfers on a rising clk edge where ev_valid && ev_ready.
// While ev_valid is high and not yet accepted, the source holds ev_on, ev_note,
// ev_velocity and ev_frequency stable. ev_ready does not depend on ev_valid.
interface synth_voice_allocator_if;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_on;
    logic [6:0]  ev_note;
    logic [6:0]  ev_velocity;
    logic [15:0] ev_frequency;
    logic [15:0] frequencies [7:0];
    logic [31:0] voice_volumes [7:0];
    logic [7:0]  active;
    logic [1:0]  ev_state;      // event FSM state, 0=idle 1=scan 2=apply

    modport master (
        output ev_valid, ev_on, ev_note, ev_velocity, ev_frequency,
        input  ev_ready, frequencies, voice_volumes, active, ev_state
    );

    modport slave (
        input  ev_valid, ev_on, ev_note, ev_velocity, ev_frequency,
        output ev_ready, frequencies, voice_volumes, active, ev_state
    );
endinterface

// File: rtl/synth_voice_allocator.sv
// 8-voice allocator with LRU stealing and linear attack/release envelopes.
// Events are scanned one voice per cycle, then applied in a single cycle.
module synth_voice_allocator #(
    parameter int          TICK_DIV     = 48000,
    parameter logic [31:0] ATTACK_STEP  = 32'h0001_0000,
    parameter logic [31:0] RELEASE_STEP = 32'h0001_0000,
    parameter int          VOL_SHIFT    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    synth_voice_allocator_if.slave  bus
);
    typedef enum logic [1:0] {V_IDLE, V_ATTACK, V_SUSTAIN, V_RELEASE} voice_state_t;
    typedef enum logic [1:0] {E_IDLE, E_SCAN, E_APPLY} ev_state_t;

    voice_state_t v_state  [8];
    logic [6:0]   v_note   [8];
    logic [31:0]  v_target [8];
    logic [31:0]  v_volume [8];
    logic [15:0]  v_freq   [8];
    logic [2:0]   v_age    [8];

    ev_state_t    e_state;
    logic [2:0]   scan_idx;
    logic         lat_on;
    logic [6:0]   lat_note;
    logic [6:0]   lat_vel;
    logic [15:0]  lat_freq;
    logic         hit_match, hit_idle;
    logic [2:0]   match_idx, idle_idx, old_idx;

    logic [31:0]  tick_cnt;
    logic         tick;

    logic         sc_match, sc_idle, sc_old;
    logic [2:0]   chosen;
    logic         apply_valid, apply_en;
    logic [2:0]   old_age;
    logic [32:0]  att_sum  [8];
    logic [32:0]  rel_diff [8];

    assign tick = (tick_cnt == 32'(TICK_DIV - 1));

    // Examine the voice under the scan pointer against the latched event.
    always_comb begin
        sc_idle  = (v_state[scan_idx] == V_IDLE);
        sc_old   = (v_age[scan_idx] == 3'd7);
        sc_match = 1'b0;
        if (v_note[scan_idx] == lat_note) begin
            if (lat_on)
                sc_match = (v_state[scan_idx] != V_IDLE);
            else
                sc_match = (v_state[scan_idx] == V_ATTACK) || (v_state[scan_idx] == V_SUSTAIN);
        end
    end

    // Pick the voice the event lands on: match, then free voice, then oldest.
    always_comb begin
        chosen      = old_idx;
        apply_valid = 1'b0;
        if (lat_on) begin
            apply_valid = 1'b1;
            if (hit_match)
                chosen = match_idx;
            else if (hit_idle)
                chosen = idle_idx;
        end else begin
            apply_valid = hit_match;
            chosen      = match_idx;
        end
        apply_en = (e_state == E_APPLY) && apply_valid;
        old_age  = v_age[chosen];
    end

    // Saturating envelope arithmetic in 33 bits so nothing wraps.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            att_sum[i]  = {1'b0, v_volume[i]} + {1'b0, ATTACK_STEP};
            rel_diff[i] = {1'b0, v_volume[i]} - {1'b0, RELEASE_STEP};
        end
    end

    // Free-running envelope tick divider.
    always_ff @(posedge clk) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 32'd1;
    end

    // Event FSM: latch on handshake, scan voices 0..7, apply for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_state   <= E_IDLE;
            scan_idx  <= '0;
            lat_on    <= 1'b0;
            lat_note  <= '0;
            lat_vel   <= '0;
            lat_freq  <= '0;
            hit_match <= 1'b0;
            hit_idle  <= 1'b0;
            match_idx <= '0;
            idle_idx  <= '0;
            old_idx   <= '0;
        end else begin
            case (e_state)
                E_IDLE: begin
                    if (bus.ev_valid) begin
                        lat_on    <= bus.ev_on;
                        lat_note  <= bus.ev_note;
                        lat_vel   <= bus.ev_velocity;
                        lat_freq  <= bus.ev_frequency;
                        hit_match <= 1'b0;
                        hit_idle  <= 1'b0;
                        scan_idx  <= '0;
                        e_state   <= E_SCAN;
                    end
                end
                E_SCAN: begin
                    if (sc_match && !hit_match) begin
                        hit_match <= 1'b1;
                        match_idx <= scan_idx;
                    end
                    if (sc_idle && !hit_idle) begin
                        hit_idle <= 1'b1;
                        idle_idx <= scan_idx;
                    end
                    if (sc_old)
                        old_idx <= scan_idx;
                    scan_idx <= scan_idx + 3'd1;
                    if (scan_idx == 3'd7)
                        e_state <= E_APPLY;
                end
                E_APPLY: e_state <= E_IDLE;
                default: e_state <= E_IDLE;
            endcase
        end
    end

    // Per-voice registers: event apply takes priority over the envelope tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                v_state[i]  <= V_IDLE;
                v_note[i]   <= '0;
                v_target[i] <= '0;
                v_volume[i] <= '0;
                v_freq[i]   <= 16'd440;
                v_age[i]    <= 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (apply_en && lat_on) begin
                    if (chosen == 3'(i))
                        v_age[i] <= 3'd0;
                    else if (v_age[i] < old_age)
                        v_age[i] <= v_age[i] + 3'd1;
                end
                if (apply_en && (chosen == 3'(i))) begin
                    if (lat_on) begin
                        v_state[i]  <= V_ATTACK;
                        v_note[i]   <= lat_note;
                        v_target[i] <= 32'(lat_vel) << VOL_SHIFT;
                        v_freq[i]   <= lat_freq;
                        if (!hit_match)
                            v_volume[i] <= '0;
                    end else begin
                        v_state[i] <= V_RELEASE;
                    end
                end else if (tick) begin
                    case (v_state[i])
                        V_ATTACK: begin
                            if (att_sum[i] >= {1'b0, v_target[i]}) begin
                                v_volume[i] <= v_target[i];
                                v_state[i]  <= V_SUSTAIN;
                            end else begin
                                v_volume[i] <= att_sum[i][31:0];
                            end
                        end
                        V_SUSTAIN: v_volume[i] <= v_target[i];
                        V_RELEASE: begin
                            if (rel_diff[i][32] || (rel_diff[i][31:0] == 32'd0)) begin
                                v_volume[i] <= '0;
                                v_state[i]  <= V_IDLE;
                            end else begin
                                v_volume[i] <= rel_diff[i][31:0];
                            end
                        end
                        default: v_volume[i] <= '0;
                    endcase
                end
            end
        end
    end

    // Outputs are straight decodes of registers.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            bus.frequencies[i]   = v_freq[i];
            bus.voice_volumes[i] = v_volume[i];
            bus.active[i]        = (v_state[i] != V_IDLE);
        end
        bus.ev_ready = (e_state == E_IDLE);
        bus.ev_state = e_state;
    end
endmodule
